// File: rtl/ycbcr_src_arbiter_if.sv
// -----------------------------------------------------------------------------
// ycbcr_src_arbiter_if
// Video bus carried between an RGB source, the arbiter and the colour-space
// converter: frame valid, line/pixel valid and one RGB pixel.
//   vsync  frame valid, high for the whole frame
//   herf   line/pixel valid
//   red/green/blue  pixel components, DATA_W bits each
// Modports:
//   master  drives the bus (arbiter towards the converter)
//   slave   receives the bus (arbiter from a source)
// -----------------------------------------------------------------------------
interface ycbcr_src_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              vsync;
   logic              herf;
   logic [DATA_W-1:0] red;
   logic [DATA_W-1:0] green;
   logic [DATA_W-1:0] blue;

   modport master (output vsync, herf, red, green, blue);
   modport slave  (input  vsync, herf, red, green, blue);
endinterface

// File: rtl/ycbcr_src_arbiter.sv
// -----------------------------------------------------------------------------
// ycbcr_src_arbiter
// Shares one RGB-to-YCbCr converter between two free-running RGB sources.
// The converter is granted to one source for a whole frame (round-robin on a
// simultaneous start), the converter pipeline is drained for DRAIN_CYC idle
// cycles after each granted frame, and converter output is tagged with the
// originating source. Frames that cannot be served are dropped and counted.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_src_en[1:0]  per-source enable, bit i = source i
//   i_s0, i_s1     source video buses (slave modport)
//   o_cv           muxed video bus to the converter (master modport)
//   o_post_src     source id aligned with converter output (CONV_LAT later)
//   o_busy         high while a frame is granted or the pipeline drains
//   o_drop_cnt0/1  saturating dropped-frame counters
// Latency: source pin to o_cv is 2 cycles (input register + output register).
// -----------------------------------------------------------------------------
module ycbcr_src_arbiter #(
   parameter int DATA_W    = 8,
   parameter int CONV_LAT  = 3,
   parameter int DRAIN_CYC = 4,
   parameter int DROP_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          i_src_en,
   ycbcr_src_arbiter_if.slave  i_s0,
   ycbcr_src_arbiter_if.slave  i_s1,
   ycbcr_src_arbiter_if.master o_cv,
   output logic                o_post_src,
   output logic                o_busy,
   output logic [DROP_W-1:0]   o_drop_cnt0,
   output logic [DROP_W-1:0]   o_drop_cnt1
);

   localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // input stage registers (index = source id)
   logic [1:0]        r_vs_p1;
   logic [1:0]        r_vs_p2;
   logic [1:0]        r_hf_p1;
   logic [DATA_W-1:0] r_red_p1 [2];
   logic [DATA_W-1:0] r_grn_p1 [2];
   logic [DATA_W-1:0] r_blu_p1 [2];
   logic [1:0]        r_armed;

   // control and output registers
   state_t            r_state;
   logic              r_rr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cv_vs;
   logic              r_cv_hf;
   logic [DATA_W-1:0] r_cv_red;
   logic [DATA_W-1:0] r_cv_grn;
   logic [DATA_W-1:0] r_cv_blu;
   logic              r_cv_id;
   logic [CONV_LAT-1:0] r_id_sr;
   logic [DROP_W-1:0] r_drop0;
   logic [DROP_W-1:0] r_drop1;

   // next-state signals
   logic [1:0]        w_start;
   state_t            w_state_nxt;
   logic              w_rr_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_pass;
   logic              w_sel;
   logic [1:0]        w_drop;

   // ---- stage p1/p2: register source pins, vsync history for edge detect ----
   // vsync stages reset high so that the reset value never looks like a "low"
   // sample: a source only arms after genuinely showing vsync low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_p1 <= 2'b11;
         r_vs_p2 <= 2'b11;
         r_hf_p1 <= 2'b00;
         r_armed <= 2'b00;
      end else begin
         r_vs_p1 <= {i_s1.vsync, i_s0.vsync};
         r_vs_p2 <= r_vs_p1;
         r_hf_p1 <= {i_s1.herf, i_s0.herf};
         r_armed <= r_armed | ~r_vs_p1;
      end
   end

   always_ff @(posedge clk) begin
      r_red_p1[0] <= i_s0.red;
      r_grn_p1[0] <= i_s0.green;
      r_blu_p1[0] <= i_s0.blue;
      r_red_p1[1] <= i_s1.red;
      r_grn_p1[1] <= i_s1.green;
      r_blu_p1[1] <= i_s1.blue;
   end

   assign w_start = r_vs_p1 & ~r_vs_p2 & r_armed & i_src_en;

   // ---- arbitration: next state, selected source, drop events ----
   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr;
      w_cnt_nxt   = '0;
      w_pass      = 1'b0;
      w_sel       = 1'b0;
      w_drop      = 2'b00;
      case (r_state)
         IDLE: begin
            // single start: pick it; simultaneous starts: the favoured one
            w_sel = (w_start == 2'b11) ? r_rr : w_start[1];
            if (w_start != 2'b00) begin
               w_pass      = 1'b1;
               w_state_nxt = w_sel ? GRANT1 : GRANT0;
               if (w_start == 2'b11)
                  w_drop = w_sel ? 2'b01 : 2'b10;
            end
         end
         GRANT0, GRANT1: begin
            w_sel  = (r_state == GRANT1);
            w_pass = 1'b1;
            w_drop = w_start;
            // the frame-end sample is still passed so cv_vsync falls cleanly
            if (!r_vs_p1[w_sel]) begin
               w_state_nxt = DRAIN;
               w_rr_nxt    = ~w_sel;
            end
         end
         DRAIN: begin
            w_drop = w_start;
            if (r_cnt == CNT_W'(DRAIN_CYC - 1))
               w_state_nxt = IDLE;
            else
               w_cnt_nxt = r_cnt + 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---- stage p3: converter output register, id tag, counters ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_rr     <= 1'b0;
         r_cnt    <= '0;
         r_cv_vs  <= 1'b0;
         r_cv_hf  <= 1'b0;
         r_cv_red <= '0;
         r_cv_grn <= '0;
         r_cv_blu <= '0;
         r_cv_id  <= 1'b0;
         r_id_sr  <= '0;
         r_drop0  <= '0;
         r_drop1  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rr    <= w_rr_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_pass) begin
            r_cv_vs  <= r_vs_p1[w_sel];
            r_cv_hf  <= r_hf_p1[w_sel];
            r_cv_red <= r_red_p1[w_sel];
            r_cv_grn <= r_grn_p1[w_sel];
            r_cv_blu <= r_blu_p1[w_sel];
            r_cv_id  <= w_sel;
         end else begin
            r_cv_vs  <= 1'b0;
            r_cv_hf  <= 1'b0;
            r_cv_red <= '0;
            r_cv_grn <= '0;
            r_cv_blu <= '0;
         end
         // id follows cv_* through the converter; holds its value when idle
         r_id_sr[0] <= r_cv_id;
         for (int k = 1; k < CONV_LAT; k++)
            r_id_sr[k] <= r_id_sr[k-1];
         if (w_drop[0]) r_drop0 <= sat_inc(r_drop0);
         if (w_drop[1]) r_drop1 <= sat_inc(r_drop1);
      end
   end

   assign o_cv.vsync  = r_cv_vs;
   assign o_cv.herf   = r_cv_hf;
   assign o_cv.red    = r_cv_red;
   assign o_cv.green  = r_cv_grn;
   assign o_cv.blue   = r_cv_blu;
   assign o_post_src  = r_id_sr[CONV_LAT-1];
   assign o_busy      = (r_state != IDLE);
   assign o_drop_cnt0 = r_drop0;
   assign o_drop_cnt1 = r_drop1;

endmodule

// File: tb/tb_ycbcr_src_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ycbcr_src_arbiter
// Directed testbench for ycbcr_src_arbiter (CONV_LAT=3, DRAIN_CYC=4, DROP_W=2).
// Each step drives both source buses, waits for the next rising edge and looks
// at the outputs 1 time unit later. cv_* is expected to equal the pins of the
// granted source driven one step earlier than the most recent step.
// -----------------------------------------------------------------------------
module tb_ycbcr_src_arbiter;

   localparam int CONV_LAT  = 3;
   localparam int DRAIN_CYC = 4;
   localparam int DROP_W    = 2;

   typedef struct packed {
      logic       v;
      logic       h;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [1:0]        src_en = 2'b11;
   logic              post_src;
   logic              busy;
   logic [DROP_W-1:0] drop0;
   logic [DROP_W-1:0] drop1;

   ycbcr_src_arbiter_if s0_if ();
   ycbcr_src_arbiter_if s1_if ();
   ycbcr_src_arbiter_if cv_if ();

   int n_cmp  = 0;
   int n_fail = 0;

   pix_t prev1_0 = '0, prev2_0 = '0, prev1_1 = '0, prev2_1 = '0;
   pix_t cv_now;
   assign cv_now = {cv_if.vsync, cv_if.herf, cv_if.red, cv_if.green, cv_if.blue};

   always #5 clk = ~clk;

   ycbcr_src_arbiter #(
      .DATA_W(8), .CONV_LAT(CONV_LAT), .DRAIN_CYC(DRAIN_CYC), .DROP_W(DROP_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_src_en(src_en),
      .i_s0(s0_if),
      .i_s1(s1_if),
      .o_cv(cv_if),
      .o_post_src(post_src),
      .o_busy(busy),
      .o_drop_cnt0(drop0),
      .o_drop_cnt1(drop1)
   );

   function automatic pix_t mkpix(input logic v, input logic h, input logic [7:0] base, input int k);
      pix_t p;
      p = '0;
      if (v) begin
         p.v = 1'b1;
         p.h = h;
         p.r = base + 8'(k);
         p.g = base + 8'(k) + 8'h20;
         p.b = base + 8'(k) + 8'h40;
      end
      return p;
   endfunction

   task automatic drive(input pix_t p0, input pix_t p1);
      s0_if.vsync = p0.v; s0_if.herf = p0.h;
      s0_if.red = p0.r;   s0_if.green = p0.g; s0_if.blue = p0.b;
      s1_if.vsync = p1.v; s1_if.herf = p1.h;
      s1_if.red = p1.r;   s1_if.green = p1.g; s1_if.blue = p1.b;
      prev2_0 = prev1_0; prev1_0 = p0;
      prev2_1 = prev1_1; prev1_1 = p1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      src_en = 2'b11;
      drive('0, '0);
      drive('0, '0);
      rst_n = 1'b1;
      drive('0, '0);
      drive('0, '0);
      drive('0, '0);
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      drive('0, '0);
      drive('0, '0);
      n_cmp++; if (cv_now !== '0)   begin n_fail++; $display("FAIL reset_cv: got %h, want 0", cv_now); end
      n_cmp++; if (post_src !== 1'b0) begin n_fail++; $display("FAIL reset_post_src: got %b, want 0", post_src); end
      n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy); end
      n_cmp++; if (drop0 !== 2'd0)  begin n_fail++; $display("FAIL reset_drop0: got %0d, want 0", drop0); end
      n_cmp++; if (drop1 !== 2'd0)  begin n_fail++; $display("FAIL reset_drop1: got %0d, want 0", drop1); end
   endtask

   // source 0 alone, 4 lines x 8 pixels, R=G=B=0x80
   task automatic test_single_src0();
      pix_t p;
      do_reset();
      for (int k = 0; k < 52; k++) begin
         p = '0;
         if (k < 41) begin
            p.v = 1'b1;
            p.h = (k >= 1) && (((k - 1) % 10) < 8);
            p.r = 8'h80; p.g = 8'h80; p.b = 8'h80;
         end
         drive(p, '0);
         n_cmp++; if (cv_now !== prev2_0) begin n_fail++; $display("FAIL single_cv k=%0d: got %h, want %h", k, cv_now, prev2_0); end
         n_cmp++; if (post_src !== 1'b0) begin n_fail++; $display("FAIL single_post_src k=%0d: got %b, want 0", k, post_src); end
      end
      n_cmp++; if (drop0 !== 2'd0) begin n_fail++; $display("FAIL single_drop0: got %0d, want 0", drop0); end
   endtask

   // simultaneous starts: source 0 first, then source 1
   task automatic test_round_robin();
      pix_t p0, p1;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         p0 = (k < 6) ? mkpix(1'b1, (k >= 1) && (k <= 4), 8'h10, k) : '0;
         p1 = (k < 6) ? mkpix(1'b1, (k >= 1) && (k <= 4), 8'h80, k) : '0;
         drive(p0, p1);
         n_cmp++; if (cv_now !== prev2_0) begin n_fail++; $display("FAIL rr1_cv k=%0d: got %h, want %h", k, cv_now, prev2_0); end
      end
      n_cmp++; if (drop1 !== 2'd1) begin n_fail++; $display("FAIL rr1_drop1: got %0d, want 1", drop1); end
      n_cmp++; if (drop0 !== 2'd0) begin n_fail++; $display("FAIL rr1_drop0: got %0d, want 0", drop0); end
      for (int k = 0; k < 16; k++) begin
         p0 = (k < 6) ? mkpix(1'b1, (k >= 1) && (k <= 4), 8'h10, k) : '0;
         p1 = (k < 6) ? mkpix(1'b1, (k >= 1) && (k <= 4), 8'h80, k) : '0;
         drive(p0, p1);
         n_cmp++; if (cv_now !== prev2_1) begin n_fail++; $display("FAIL rr2_cv k=%0d: got %h, want %h", k, cv_now, prev2_1); end
         if (k == 3) begin
            n_cmp++; if (post_src !== 1'b0) begin n_fail++; $display("FAIL rr2_post_src_early: got %b, want 0", post_src); end
         end
         if (k == 4) begin
            n_cmp++; if (post_src !== 1'b1) begin n_fail++; $display("FAIL rr2_post_src: got %b, want 1", post_src); end
         end
      end
      n_cmp++; if (drop0 !== 2'd1) begin n_fail++; $display("FAIL rr2_drop0: got %0d, want 1", drop0); end
      n_cmp++; if (drop1 !== 2'd1) begin n_fail++; $display("FAIL rr2_drop1: got %0d, want 1", drop1); end
   endtask

   // source 1 starts 5 cycles into a source 0 frame
   task automatic test_drop_mid_frame();
      pix_t p0, p1;
      logic exp_busy;
      do_reset();
      for (int k = 0; k < 21; k++) begin
         p0 = (k < 10) ? mkpix(1'b1, (k >= 1) && (k <= 8), 8'h20, k) : '0;
         p1 = (k >= 5 && k <= 12) ? mkpix(1'b1, (k >= 6) && (k <= 11), 8'hA0, k) : '0;
         drive(p0, p1);
         exp_busy = (k >= 1) && (k <= 14);
         n_cmp++; if (cv_now !== prev2_0) begin n_fail++; $display("FAIL mid_cv k=%0d: got %h, want %h", k, cv_now, prev2_0); end
         n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL mid_busy k=%0d: got %b, want %b", k, busy, exp_busy); end
      end
      n_cmp++; if (drop1 !== 2'd1) begin n_fail++; $display("FAIL mid_drop1: got %0d, want 1", drop1); end
      n_cmp++; if (drop0 !== 2'd0) begin n_fail++; $display("FAIL mid_drop0: got %0d, want 0", drop0); end
   endtask

   // source 1 start one cycle before / exactly at the end of DRAIN
   task automatic test_drain_edge();
      pix_t p0, p1;
      pix_t exp_cv;
      logic [1:0] exp_d1;
      int rise;
      for (int c = 0; c < 2; c++) begin
         rise = 10 + c;
         do_reset();
         for (int k = 0; k < 26; k++) begin
            p0 = (k < 6) ? mkpix(1'b1, (k >= 1) && (k <= 4), 8'h30, k) : '0;
            p1 = (k >= rise && k < rise + 7) ? mkpix(1'b1, (k > rise) && (k <= rise + 5), 8'hC0, k) : '0;
            drive(p0, p1);
            exp_cv = (c == 1 && k > 8) ? prev2_1 : prev2_0;
            n_cmp++; if (cv_now !== exp_cv) begin n_fail++; $display("FAIL drain%0d_cv k=%0d: got %h, want %h", c, k, cv_now, exp_cv); end
            if (k == 10) begin
               n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain%0d_busy_last: got %b, want 1", c, busy); end
            end
            if (k == 11) begin
               n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain%0d_busy_idle: got %b, want 0", c, busy); end
            end
            if (k == 15) begin
               n_cmp++; if (post_src !== 1'(c)) begin n_fail++; $display("FAIL drain%0d_post_src: got %b, want %0d", c, post_src, c); end
            end
         end
         exp_d1 = (c == 0) ? 2'd1 : 2'd0;
         n_cmp++; if (drop1 !== exp_d1) begin n_fail++; $display("FAIL drain%0d_drop1: got %0d, want %0d", c, drop1, exp_d1); end
         n_cmp++; if (drop0 !== 2'd0) begin n_fail++; $display("FAIL drain%0d_drop0: got %0d, want 0", c, drop0); end
      end
   endtask

   // reset asserted mid-frame, released with vsync still high
   task automatic test_reset_mid_frame();
      pix_t p0;
      pix_t exp_cv;
      do_reset();
      for (int k = 0; k < 4; k++) drive(mkpix(1'b1, 1'b1, 8'h50, k), '0);
      n_cmp++; if (cv_now !== prev2_0) begin n_fail++; $display("FAIL rmid_cv_granted: got %h, want %h", cv_now, prev2_0); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (cv_now !== '0) begin n_fail++; $display("FAIL rmid_cv_async: got %h, want 0", cv_now); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_async: got %b, want 0", busy); end
      drive(mkpix(1'b1, 1'b1, 8'h50, 4), '0);
      drive(mkpix(1'b1, 1'b1, 8'h50, 5), '0);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         p0 = (k < 8 || k >= 10) ? mkpix(1'b1, (k != 10), 8'h58, k) : '0;
         drive(p0, '0);
         exp_cv = (k >= 11) ? prev2_0 : '0;
         n_cmp++; if (cv_now !== exp_cv) begin n_fail++; $display("FAIL rmid_cv k=%0d: got %h, want %h", k, cv_now, exp_cv); end
         n_cmp++; if (busy !== (k >= 11)) begin n_fail++; $display("FAIL rmid_busy k=%0d: got %b, want %b", k, busy, (k >= 11)); end
      end
   endtask

   // 1-cycle vsync-low glitch on the granted source
   task automatic test_glitch();
      pix_t p0;
      pix_t exp_cv;
      do_reset();
      for (int k = 0; k < 21; k++) begin
         p0 = (k != 5 && k <= 10) ? mkpix(1'b1, 1'b1, 8'h60, k) : '0;
         drive(p0, '0);
         exp_cv = (k <= 6) ? prev2_0 : '0;
         n_cmp++; if (cv_now !== exp_cv) begin n_fail++; $display("FAIL glitch_cv k=%0d: got %h, want %h", k, cv_now, exp_cv); end
         n_cmp++; if (busy !== (k >= 1 && k <= 9)) begin n_fail++; $display("FAIL glitch_busy k=%0d: got %b, want %b", k, busy, (k >= 1 && k <= 9)); end
      end
      n_cmp++; if (drop0 !== 2'd1) begin n_fail++; $display("FAIL glitch_drop0: got %0d, want 1", drop0); end
      n_cmp++; if (drop1 !== 2'd0) begin n_fail++; $display("FAIL glitch_drop1: got %0d, want 0", drop1); end
   endtask

   // counter saturation and disabled source
   task automatic test_saturate_and_enable();
      pix_t p0, p1;
      logic [1:0] exp_d1;
      int f;
      do_reset();
      for (int k = 0; k < 90; k++) begin
         p0 = (k < 80) ? mkpix(1'b1, 1'b1, 8'h08, k) : '0;
         p1 = (k >= 8 && k < 48 && ((k - 8) % 8) < 4) ? mkpix(1'b1, 1'b1, 8'hE0, k) : '0;
         drive(p0, p1);
         n_cmp++; if (cv_now !== prev2_0) begin n_fail++; $display("FAIL sat_cv k=%0d: got %h, want %h", k, cv_now, prev2_0); end
         if (k >= 15 && k < 48 && ((k - 15) % 8) == 0) begin
            f = (k - 15) / 8 + 1;
            exp_d1 = (f > 3) ? 2'd3 : 2'(f);
            n_cmp++; if (drop1 !== exp_d1) begin n_fail++; $display("FAIL sat_drop1 frame=%0d: got %0d, want %0d", f, drop1, exp_d1); end
         end
      end
      n_cmp++; if (drop0 !== 2'd0) begin n_fail++; $display("FAIL sat_drop0: got %0d, want 0", drop0); end

      do_reset();
      src_en = 2'b01;
      for (int k = 0; k < 56; k++) begin
         p0 = (k >= 30 && k <= 45) ? mkpix(1'b1, 1'b1, 8'h44, k) : '0;
         p1 = ((k < 30 && (k % 10) < 5) || (k >= 35 && k <= 40)) ? mkpix(1'b1, 1'b1, 8'hB0, k) : '0;
         drive(p0, p1);
         n_cmp++; if (cv_now !== prev2_0) begin n_fail++; $display("FAIL en_cv k=%0d: got %h, want %h", k, cv_now, prev2_0); end
         if (k <= 30) begin
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_busy k=%0d: got %b, want 0", k, busy); end
         end
      end
      n_cmp++; if (drop1 !== 2'd0) begin n_fail++; $display("FAIL en_drop1: got %0d, want 0", drop1); end
      n_cmp++; if (post_src !== 1'b0) begin n_fail++; $display("FAIL en_post_src: got %b, want 0", post_src); end
   endtask

   initial begin
      s0_if.vsync = 1'b0; s0_if.herf = 1'b0; s0_if.red = '0; s0_if.green = '0; s0_if.blue = '0;
      s1_if.vsync = 1'b0; s1_if.herf = 1'b0; s1_if.red = '0; s1_if.green = '0; s1_if.blue = '0;
      test_reset();
      test_single_src0();
      test_round_robin();
      test_drop_mid_frame();
      test_drain_edge();
      test_reset_mid_frame();
      test_glitch();
      test_saturate_and_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
